uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
APB master that owns the UART register interface for transmit traffic.
- After reset it programs baud divisor, line control and IER.
- It then arbitrates round-robin between two byte requesters.
- For each granted byte it polls LSR.THRE and writes THR.
- It sits between on-chip byte sources (boot console, hardware trace logger) and the uart APB slave port. The uart APB has no pready: every access is fixed 2 cycles.

Parameters:
BASE_ADDR, 40'h0, UART base address; register offsets are added to it.
RESET_DIVISOR, 16'd27, baud divisor programmed by the post-reset init sequence.
POLL_MAX, 16'd4095, number of LSR reads without THRE before the byte is dropped.

Ports:
sys_clk  in  1  single clock
rst_b  in  1  asynchronous active-low reset
apb_uart_paddr  out  40  APB address
apb_uart_psel  out  1  APB select
apb_uart_penable  out  1  APB enable (access phase)
apb_uart_pwrite  out  1  APB write
apb_uart_pwdata  out  32  APB write data, bits [31:8] always 0
uart_apb_prdata  in  32  APB read data
cfg_divisor  in  16  new divisor, sampled with cfg_update
cfg_update  in  1  1-cycle pulse: reprogram divisor/LCR
req0 / req1  in  1  byte request, held until ack
data0 / data1  in  8  byte, stable while req high
ack0 / ack1  out  1  1-cycle pulse: byte written or dropped
drop  out  1  1-cycle pulse with ack when byte dropped on poll timeout
err_sticky  out  1  set on any drop, cleared only by reset
init_done  out  1  high when divisor/LCR programming is complete

Behaviour:
- Register offsets are fixed: THR/DLL 0x00, DLH 0x04, LCR 0x0C, LSR 0x14. IER is 0x04 with DLAB=0.
- APB access is 2 cycles:
  - setup: psel=1, penable=0.
  - access: psel=1, penable=1.
  - paddr/pwrite/pwdata are held constant across both cycles.
  - prdata is sampled at the end of the access cycle.
  - Back-to-back accesses are allowed with no idle cycle between them.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, ack0=ack1=0, drop=0, err_sticky=0, init_done=0.
- Reset also sets: FSM=INIT_LCR1, rr pointer=1 (req0 wins the first tie), divisor register=RESET_DIVISOR, poll counter=0.
- FSM states: INIT_LCR1, INIT_DLL, INIT_DLH, INIT_LCR2, INIT_IER, IDLE, POLL, WR_THR.
- Init writes, one state per access:
  - INIT_LCR1 writes LCR=0x83 (DLAB=1, 8 data bits, 1 stop bit, no parity).
  - INIT_DLL writes div[7:0]; INIT_DLH writes div[15:8].
  - INIT_LCR2 writes LCR=0x03; INIT_IER writes IER=0x00.
  - Each write is 2 cycles, so init takes 10 cycles. init_done rises the cycle after the INIT_IER access cycle and stays high.
- IDLE priority:
  1. A pending cfg_update wins. It clears init_done and jumps to INIT_LCR1 using the latched cfg_divisor.
  2. Otherwise grant a requester. With both req high, grant the one not granted last; with one high, grant it. Record the grant and the byte, update the rr pointer, go to POLL.
- cfg_update may pulse in any state; it is latched as pending and taken at the next IDLE. A second pulse before then overwrites the latched divisor.
- POLL: reads LSR.
  - If prdata[5]=1 (THRE): go to WR_THR.
  - Else increment the poll counter. When the counter reaches POLL_MAX: pulse ack(granted) and drop, set err_sticky, clear the counter, go to IDLE.
  - Otherwise re-read LSR immediately.
- WR_THR: writes the byte to THR. ack(granted) pulses in the THR access cycle. Next state is IDLE; the poll counter is cleared.
- Latency:
  - req is first sampled high in IDLE at cycle T.
  - LSR read occupies T+1 and T+2.
  - If THRE=1 on that first read, THR write occupies T+3 and T+4; ack is high in cycle T+4.
  - Sustained single-requester throughput is one byte per 5 cycles plus UART drain time.
- Requests are not served before init_done. A req asserted during init is held and served in the first IDLE cycle.
- A requester dropping req before ack is a protocol violation and its behaviour is undefined. Its byte is still written.
- rst_b asserted mid-transfer aborts the transfer asynchronously. psel drops immediately and init restarts after reset deassertion.

Test Plan:
- Reset then idle, RESET_DIVISOR=27: APB writes in order are 0x0C←0x83, 0x00←0x1B, 0x04←0x00, 0x0C←0x03, 0x04←0x00. init_done=1 at cycle 11.
- req0 with data0=0x41, LSR returns 0x60: LSR read at 0x14, then THR write 0x00←0x41. ack0 pulses at T+4; ack1 stays 0.
- req0 and req1 held high, data 0x11 and 0x22, THRE always 1: THR write sequence 0x11, 0x22, 0x11, 0x22, with acks alternating ack0, ack1.
- LSR returns 0x00 for 3 reads then 0x20: four LSR reads, then the THR write. No drop pulse.
- POLL_MAX=4 with THRE never set: exactly 4 LSR reads, then ack1 and drop pulse together and err_sticky=1. The next request is served normally.
- cfg_update with cfg_divisor=0x0102 during a transfer: the current byte completes, then init_done=0, DLL←0x02, DLH←0x01, LCR←0x03 and init_done returns to 1. Assert rst_b mid-POLL: psel=0 at once.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// APB master that initialises a 16550-style UART and then streams bytes from two
// round-robin requesters into THR, polling LSR.THRE before every write.
module uart_tx_sequencer #(
    parameter logic [39:0] BASE_ADDR     = 40'h0,
    parameter logic [15:0] RESET_DIVISOR = 16'd27,
    parameter logic [15:0] POLL_MAX      = 16'd4095
) (
    input  logic        sys_clk,
    input  logic        rst_b,
    output logic [39:0] apb_uart_paddr,
    output logic        apb_uart_psel,
    output logic        apb_uart_penable,
    output logic        apb_uart_pwrite,
    output logic [31:0] apb_uart_pwdata,
    input  logic [31:0] uart_apb_prdata,
    input  logic [15:0] cfg_divisor,
    input  logic        cfg_update,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    output logic        ack0,
    output logic        ack1,
    output logic        drop,
    output logic        err_sticky,
    output logic        init_done
);

    typedef enum logic [2:0] {
        S_INIT_LCR1 = 3'd0,
        S_INIT_DLL  = 3'd1,
        S_INIT_DLH  = 3'd2,
        S_INIT_LCR2 = 3'd3,
        S_INIT_IER  = 3'd4,
        S_IDLE      = 3'd5,
        S_POLL      = 3'd6,
        S_WR_THR    = 3'd7
    } state_t;

    localparam logic [39:0] OFF_THR = 40'h00;
    localparam logic [39:0] OFF_DLH = 40'h04;
    localparam logic [39:0] OFF_LCR = 40'h0C;
    localparam logic [39:0] OFF_LSR = 40'h14;

    state_t      r_state, w_state_nxt;
    logic        r_psel, w_psel_nxt;
    logic        r_penable, w_penable_nxt;
    logic        r_pwrite, w_pwrite_nxt;
    logic [39:0] r_paddr, w_paddr_nxt;
    logic [7:0]  r_pwdata, w_pwdata_nxt;
    logic        r_ack0, w_ack0_nxt;
    logic        r_ack1, w_ack1_nxt;
    logic        r_drop, w_drop_nxt;
    logic        r_err, w_err_nxt;
    logic        r_init_done, w_init_done_nxt;
    logic        r_last, w_last_nxt;
    logic        r_gnt, w_gnt_nxt;
    logic [7:0]  r_byte, w_byte_nxt;
    logic [15:0] r_div, w_div_nxt;
    logic [15:0] r_poll_cnt, w_poll_nxt;
    logic        r_cfg_pend;
    logic [15:0] r_cfg_div;
    logic        w_cfg_take;
    logic        w_launch;
    logic        w_setup;
    logic        w_acc_done;
    logic        w_req0_m;
    logic        w_req1_m;
    logic [16:0] w_poll_inc;
    logic        w_unused_prdata;

    assign w_setup    = r_psel & ~r_penable;
    assign w_acc_done = r_psel & r_penable;
    // A requester whose ack is on the wire this cycle has not yet seen it; don't re-grant it.
    assign w_req0_m   = req0 & ~r_ack0;
    assign w_req1_m   = req1 & ~r_ack1;
    assign w_poll_inc = {1'b0, r_poll_cnt} + 17'd1;
    assign w_unused_prdata = ^{uart_apb_prdata[31:6], uart_apb_prdata[4:0]};

    // Next-state, bus launch and handshake decode
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_ack0_nxt      = 1'b0;
        w_ack1_nxt      = 1'b0;
        w_drop_nxt      = 1'b0;
        w_err_nxt       = r_err;
        w_init_done_nxt = r_init_done;
        w_last_nxt      = r_last;
        w_gnt_nxt       = r_gnt;
        w_byte_nxt      = r_byte;
        w_div_nxt       = r_div;
        w_poll_nxt      = r_poll_cnt;
        w_cfg_take      = 1'b0;
        w_launch        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_cfg_pend) begin
                    w_cfg_take      = 1'b1;
                    w_div_nxt       = r_cfg_div;
                    w_init_done_nxt = 1'b0;
                    w_state_nxt     = S_INIT_LCR1;
                    w_launch        = 1'b1;
                end else if (w_req0_m || w_req1_m) begin
                    if (w_req0_m && w_req1_m) begin
                        w_gnt_nxt = ~r_last;
                    end else begin
                        w_gnt_nxt = w_req1_m;
                    end
                    w_byte_nxt  = w_gnt_nxt ? data1 : data0;
                    w_last_nxt  = w_gnt_nxt;
                    w_state_nxt = S_POLL;
                    w_launch    = 1'b1;
                end else begin
                    w_launch = 1'b0;
                end
            end
            S_POLL: begin
                if (w_acc_done) begin
                    w_launch = 1'b1;
                    if (uart_apb_prdata[5]) begin
                        w_state_nxt = S_WR_THR;
                    end else if (w_poll_inc >= {1'b0, POLL_MAX}) begin
                        w_ack0_nxt  = ~r_gnt;
                        w_ack1_nxt  = r_gnt;
                        w_drop_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_poll_nxt  = 16'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_poll_nxt = w_poll_inc[15:0];
                    end
                end else if (!r_psel) begin
                    w_launch = 1'b1;
                end else begin
                    w_launch = 1'b0;
                end
            end
            S_WR_THR: begin
                if (w_acc_done) begin
                    w_poll_nxt  = 16'd0;
                    w_state_nxt = S_IDLE;
                    w_launch    = 1'b1;
                end else if (w_setup) begin
                    w_ack0_nxt = ~r_gnt;
                    w_ack1_nxt = r_gnt;
                end else begin
                    w_launch = 1'b1;
                end
            end
            S_INIT_LCR1, S_INIT_DLL, S_INIT_DLH, S_INIT_LCR2, S_INIT_IER: begin
                if (w_acc_done) begin
                    w_launch = 1'b1;
                    case (r_state)
                        S_INIT_LCR1: w_state_nxt = S_INIT_DLL;
                        S_INIT_DLL:  w_state_nxt = S_INIT_DLH;
                        S_INIT_DLH:  w_state_nxt = S_INIT_LCR2;
                        S_INIT_LCR2: w_state_nxt = S_INIT_IER;
                        default: begin
                            w_state_nxt     = S_IDLE;
                            w_init_done_nxt = 1'b1;
                        end
                    endcase
                end else if (!r_psel) begin
                    w_launch = 1'b1;
                end else begin
                    w_launch = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_INIT_LCR1;
                w_launch    = 1'b1;
            end
        endcase

        // A launch puts the setup phase of the next state's access on the bus.
        if (w_launch) begin
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_pwrite_nxt  = 1'b1;
            case (w_state_nxt)
                S_INIT_LCR1: begin w_paddr_nxt = BASE_ADDR + OFF_LCR; w_pwdata_nxt = 8'h83; end
                S_INIT_DLL:  begin w_paddr_nxt = BASE_ADDR + OFF_THR; w_pwdata_nxt = w_div_nxt[7:0]; end
                S_INIT_DLH:  begin w_paddr_nxt = BASE_ADDR + OFF_DLH; w_pwdata_nxt = w_div_nxt[15:8]; end
                S_INIT_LCR2: begin w_paddr_nxt = BASE_ADDR + OFF_LCR; w_pwdata_nxt = 8'h03; end
                S_INIT_IER:  begin w_paddr_nxt = BASE_ADDR + OFF_DLH; w_pwdata_nxt = 8'h00; end
                S_WR_THR:    begin w_paddr_nxt = BASE_ADDR + OFF_THR; w_pwdata_nxt = w_byte_nxt; end
                S_POLL: begin
                    w_paddr_nxt  = BASE_ADDR + OFF_LSR;
                    w_pwdata_nxt = 8'h00;
                    w_pwrite_nxt = 1'b0;
                end
                default: begin
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = 1'b0;
                end
            endcase
        end else if (w_setup) begin
            w_penable_nxt = 1'b1;
        end else begin
            w_psel_nxt    = r_psel;
            w_penable_nxt = r_penable;
        end
    end

    // State, bus and handshake registers
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_INIT_LCR1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 40'h0;
            r_pwdata    <= 8'h00;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_drop      <= 1'b0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_byte      <= 8'h00;
            r_div       <= RESET_DIVISOR;
            r_poll_cnt  <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_ack0      <= w_ack0_nxt;
            r_ack1      <= w_ack1_nxt;
            r_drop      <= w_drop_nxt;
            r_err       <= w_err_nxt;
            r_init_done <= w_init_done_nxt;
            r_last      <= w_last_nxt;
            r_gnt       <= w_gnt_nxt;
            r_byte      <= w_byte_nxt;
            r_div       <= w_div_nxt;
            r_poll_cnt  <= w_poll_nxt;
        end
    end

    // Pending reprogram request; a pulse in the take cycle keeps it pending with the new divisor
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cfg_pend <= 1'b0;
            r_cfg_div  <= RESET_DIVISOR;
        end else if (cfg_update) begin
            r_cfg_pend <= 1'b1;
            r_cfg_div  <= cfg_divisor;
        end else if (w_cfg_take) begin
            r_cfg_pend <= 1'b0;
        end else begin
            r_cfg_pend <= r_cfg_pend;
        end
    end

    assign apb_uart_paddr   = r_paddr;
    assign apb_uart_psel    = r_psel;
    assign apb_uart_penable = r_penable;
    assign apb_uart_pwrite  = r_pwrite;
    assign apb_uart_pwdata  = {24'h0, r_pwdata};
    assign ack0             = r_ack0;
    assign ack1             = r_ack1;
    assign drop             = r_drop;
    assign err_sticky       = r_err;
    assign init_done        = r_init_done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Randomised scoreboard bench for uart_tx_sequencer: expected APB accesses and acks are
// queued by the stimulus and popped by independent monitors.
module tb_uart_tx_sequencer;

    localparam logic [39:0] BASE = 40'h00_A000_1000;
    localparam logic [15:0] RDIV = 16'd27;
    localparam int          PMAX = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [39:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = 32'h0;
    logic [15:0] cfg_divisor = 16'h0;
    logic        cfg_update = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  data0 = 8'h0, data1 = 8'h0;
    logic        ack0, ack1, drop, err_sticky, init_done;

    uart_tx_sequencer #(.BASE_ADDR(BASE), .RESET_DIVISOR(RDIV), .POLL_MAX(16'(PMAX))) dut (
        .sys_clk(clk), .rst_b(rst_b),
        .apb_uart_paddr(paddr), .apb_uart_psel(psel), .apb_uart_penable(penable),
        .apb_uart_pwrite(pwrite), .apb_uart_pwdata(pwdata), .uart_apb_prdata(prdata),
        .cfg_divisor(cfg_divisor), .cfg_update(cfg_update),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .drop(drop), .err_sticky(err_sticky), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [39:0] a; logic w; logic [31:0] d; } apb_t;
    typedef struct packed { logic a0; logic a1; logic dr; } ack_t;

    apb_t        exp_apb[$];
    ack_t        exp_ack[$];
    logic [31:0] lsr_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          model_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART slave: LSR values come from the scripted queue, ready when the script is empty.
    always @(negedge clk) begin
        if (rst_b && psel && penable && !pwrite) begin
            if (lsr_q.size() > 0) prdata = lsr_q.pop_front();
            else prdata = 32'h0000_0020;
        end
    end

    // APB monitor: every completed access must be the next expected one.
    always @(negedge clk) begin
        apb_t e;
        if (rst_b && psel && penable) begin
            if (exp_apb.size() == 0) begin
                checks++; failures++;
                $display("FAIL apb_unexpected actual=%0h/%0b/%0h required=none", paddr, pwrite, pwdata);
            end else begin
                e = exp_apb.pop_front();
                check("apb_addr", 64'(paddr), 64'(e.a));
                check("apb_write", 64'(pwrite), 64'(e.w));
                if (e.w) check("apb_wdata", 64'(pwdata), 64'(e.d));
            end
        end
    end

    // Handshake monitor: ack/drop pulses against the expected completion order.
    always @(negedge clk) begin
        ack_t e;
        if (rst_b && (ack0 || ack1 || drop)) begin
            if (exp_ack.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack_unexpected actual=%b%b%b required=none", ack0, ack1, drop);
            end else begin
                e = exp_ack.pop_front();
                check("ack_vector", 64'({ack0, ack1, drop}), 64'({e.a0, e.a1, e.dr}));
                if (e.dr) check("err_sticky_set", 64'(err_sticky), 64'd1);
            end
        end
    end

    task automatic push_wr(input logic [39:0] off, input logic [7:0] d);
        exp_apb.push_back('{a: BASE + off, w: 1'b1, d: {24'h0, d}});
    endtask

    task automatic push_init(input logic [15:0] div);
        push_wr(40'h0C, 8'h83);
        push_wr(40'h00, div[7:0]);
        push_wr(40'h04, div[15:8]);
        push_wr(40'h0C, 8'h03);
        push_wr(40'h04, 8'h00);
    endtask

    // Expected traffic for one byte whose first k LSR reads report THR not empty.
    task automatic push_byte(input bit who, input logic [7:0] b, input int k);
        logic [31:0] v;
        int n = (k >= PMAX) ? PMAX : k + 1;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            v[5] = (i >= k);
            lsr_q.push_back(v);
            exp_apb.push_back('{a: BASE + 40'h14, w: 1'b0, d: 32'h0});
        end
        if (k < PMAX) push_wr(40'h00, b);
        exp_ack.push_back('{a0: !who, a1: who, dr: (k >= PMAX)});
        model_last = who;
    endtask

    task automatic wait_acks(output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < 300 && (req0 || req1); n++) begin
            @(negedge clk);
            if (ack0 && req0) begin req0 = 1'b0; if (ack_cyc < 0) ack_cyc = cyc; end
            if (ack1 && req1) begin req1 = 1'b0; if (ack_cyc < 0) ack_cyc = cyc; end
        end
        checks++;
        if (req0 || req1) begin
            failures++;
            $display("FAIL ack_timeout actual=req%b%b_pending required=acked", req0, req1);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    task automatic round(input bit u0, input bit u1, input logic [7:0] d0, input logic [7:0] d1,
                         input int k0, input int k1);
        int t0, ta, k;
        repeat (2) @(negedge clk);
        if (u0 && u1) begin
            if (model_last) begin push_byte(1'b0, d0, k0); push_byte(1'b1, d1, k1); end
            else begin push_byte(1'b1, d1, k1); push_byte(1'b0, d0, k0); end
        end else if (u0) push_byte(1'b0, d0, k0);
        else push_byte(1'b1, d1, k1);
        data0 = d0; data1 = d1; req0 = u0; req1 = u1;
        t0 = cyc;
        wait_acks(ta);
        if (u0 ^ u1) begin
            k = u0 ? k0 : k1;
            check("ack_latency", 64'(ta - t0), 64'((k >= PMAX) ? 2 * PMAX + 1 : 2 * k + 4));
        end
    endtask

    task automatic release_and_time_init();
        int n = 0;
        push_init(RDIV);
        @(negedge clk);
        rst_b = 1'b1;
        while (n < 40 && !init_done) begin @(posedge clk); #1; n++; end
        check("init_done_cycle", 64'(n), 64'd11);
    endtask

    task automatic wait_level(input string name, input logic lvl);
        int n = 0;
        while (n < 40 && init_done !== lvl) begin @(negedge clk); n++; end
        check(name, 64'(init_done), 64'(lvl));
    endtask

    initial begin
        int ta;
        logic [15:0] da, db;
        logic [7:0] b0, b1;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({psel, penable, pwrite, ack0, ack1, drop, err_sticky, init_done}), 64'd0);
        check("reset_paddr", 64'(paddr), 64'd0);
        check("reset_pwdata", 64'(pwdata), 64'd0);
        release_and_time_init();

        round(1'b1, 1'b0, 8'h41, 8'h00, 0, 0);
        round(1'b1, 1'b1, 8'h11, 8'h22, 0, 0);
        round(1'b1, 1'b1, 8'h11, 8'h22, 0, 0);
        round(1'b1, 1'b0, 8'h5A, 8'h00, 3, 0);
        round(1'b0, 1'b1, 8'h00, 8'hC3, 0, PMAX + 1);
        check("err_after_drop", 64'(err_sticky), 64'd1);
        round(1'b0, 1'b1, 8'h00, 8'h7E, 1, 0);

        for (int r = 0; r < 30; r++) begin
            bit u0 = 1'($urandom_range(0, 1));
            bit u1 = 1'($urandom_range(0, 1));
            if (!u0 && !u1) u0 = 1'b1;
            round(u0, u1, 8'($urandom), 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
        end

        // Reprogram during a transfer; the second pulse's divisor must win.
        da = 16'($urandom); db = 16'h0102; b0 = 8'($urandom);
        repeat (2) @(negedge clk);
        push_byte(1'b0, b0, 1);
        push_init(db);
        data0 = b0; req0 = 1'b1;
        fork
            wait_acks(ta);
            begin
                repeat (2) @(negedge clk);
                cfg_divisor = da; cfg_update = 1'b1;
                @(negedge clk); cfg_update = 1'b0;
                @(negedge clk); cfg_divisor = db; cfg_update = 1'b1;
                @(negedge clk); cfg_update = 1'b0;
            end
        join
        wait_level("init_done_cleared", 1'b0);
        wait_level("init_done_restored", 1'b1);
        b1 = 8'($urandom);
        round(1'b1, 1'b0, b1, 8'h00, 2, 0);

        // Reset in the middle of polling aborts the bus at once.
        repeat (2) @(negedge clk);
        push_byte(1'b1, 8'hEE, PMAX + 1);
        data1 = 8'hEE; req1 = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_b = 1'b0;
        #1 check("psel_async_reset", 64'({psel, penable}), 64'd0);
        check("err_cleared_by_reset", 64'(err_sticky), 64'd0);
        req1 = 1'b0;
        exp_apb.delete(); exp_ack.delete(); lsr_q.delete();
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        release_and_time_init();
        round(1'b1, 1'b1, 8'($urandom), 8'($urandom), 0, 1);

        for (int n = 0; n < 100 && (exp_apb.size() > 0 || exp_ack.size() > 0); n++) @(negedge clk);
        check("apb_queue_drained", 64'(exp_apb.size()), 64'd0);
        check("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
        check("lsr_script_used", 64'(lsr_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
